// File: rtl/sni_pkg.sv
// Shared constants and types for the SNI host: opcodes, completion codes,
// the host sequencer state encoding and the expected-header rule.
package sni_pkg;

    localparam logic [1:0] SNI_PING    = 2'd0;
    localparam logic [1:0] SNI_READ    = 2'd1;
    localparam logic [1:0] SNI_WRITE   = 2'd2;
    localparam logic [1:0] SNI_WAITNMI = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_ECHO    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Upper byte of every word handed to the UART core.
    localparam logic [7:0] TX_HI = 8'h01;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_S_CMD  = 4'd1,
        ST_S_A0   = 4'd2,
        ST_S_A1   = 4'd3,
        ST_S_A2   = 4'd4,
        ST_S_LEN  = 4'd5,
        ST_W_HDR  = 4'd6,
        ST_R_DATA = 4'd7,
        ST_S_DATA = 4'd8,
        ST_S_PING = 4'd9,
        ST_W_ECHO = 4'd10,
        ST_FIN    = 4'd11
    } host_state_e;

    // Byte the console must answer first for a given command.
    function automatic logic [7:0] hdr_expect(input logic [1:0] op, input logic [7:0] len);
        logic [7:0] h;
        case (op)
            SNI_PING: h = 8'h01;
            SNI_READ: h = len;
            default:  h = 8'h00;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/sni_host_if.sv
// Request/data streams of the SNI host plus its UART strobe/interrupt side.
// slave is the host's view, master the view of whatever drives it.
interface sni_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [7:0]  cmd_ping;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        done;
    logic [1:0]  err_code;
    logic        stray;
    logic        tx_strobe;
    logic [15:0] tx_data;
    logic        txint;
    logic        rxint;
    logic [15:0] rdata_m;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_ping,
        input  wr_valid, wr_data, txint, rxint, rdata_m,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, err_code, stray,
        output tx_strobe, tx_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_ping,
        output wr_valid, wr_data, txint, rxint, rdata_m,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, err_code, stray,
        input  tx_strobe, tx_data
    );
endinterface

// File: rtl/sni_link.sv
// UART-side link tracking: falling-edge detection on txint/rxint, the
// one-byte-outstanding transmit busy flag and received-byte capture.
module sni_link (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_go,
    input  logic       txint,
    input  logic       rxint,
    input  logic [7:0] rx_in,
    output logic       tx_busy,
    output logic       rx_hit,
    output logic [7:0] rx_byte
);

    logic       txint_r;
    logic       rxint_r;
    logic       tx_busy_r;
    logic       rx_hit_r;
    logic [7:0] rx_byte_r;
    logic       tx_fall_s;
    logic       rx_fall_s;

    assign tx_fall_s = txint_r & ~txint;
    assign rx_fall_s = rxint_r & ~rxint;

    // Previous-cycle copies of the UART flags for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txint_r <= 1'b0;
            rxint_r <= 1'b0;
        end else begin
            txint_r <= txint;
            rxint_r <= rxint;
        end
    end

    // Busy from the strobe until the UART reports the byte gone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_busy_r <= 1'b0;
        end else if (tx_go) begin
            tx_busy_r <= 1'b1;
        end else if (tx_fall_s) begin
            tx_busy_r <= 1'b0;
        end else begin
            tx_busy_r <= tx_busy_r;
        end
    end

    // Latch the received byte on the rxint falling edge; hit pulses next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_hit_r  <= 1'b0;
            rx_byte_r <= 8'h00;
        end else begin
            rx_hit_r <= rx_fall_s;
            if (rx_fall_s) begin
                rx_byte_r <= rx_in;
            end else begin
                rx_byte_r <= rx_byte_r;
            end
        end
    end

    assign tx_busy = tx_busy_r;
    assign rx_hit  = rx_hit_r;
    assign rx_byte = rx_byte_r;

endmodule

// File: rtl/sni_host.sv
// SNI host initiator: frames PING/READ/WRITE/WAITNMI commands onto the UART,
// checks the console's header/echo replies and streams read/write payloads.
module sni_host
    import sni_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd4_000_000
) (
    input  logic     clk,
    input  logic     reset_n,
    sni_host_if.slave bus
);

    host_state_e state_r, state_s;
    logic [1:0]  op_r, op_s;
    logic [23:0] addr_r, addr_s;
    logic [7:0]  len_r, len_s;
    logic [7:0]  ping_r, ping_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [23:0] tmo_r, tmo_s;
    logic [1:0]  err_pend_r, err_pend_s;

    logic        cmd_ready_r;
    logic        wr_ready_r, wr_ready_s;
    logic        rd_valid_r, rd_valid_s;
    logic [7:0]  rd_data_r;
    logic        done_r, done_s;
    logic [1:0]  err_code_r;
    logic        stray_r, stray_s;
    logic        tx_strobe_r;
    logic [15:0] tx_data_r;
    logic        tx_go_s;
    logic [7:0]  tx_byte_s;

    logic        tx_busy_s;
    logic        rx_hit_s;
    logic [7:0]  rx_byte_s;
    logic        tmo_run_s;
    logic        tmo_hit_s;
    logic        unused_rx_hi_s;

    // The link sees the strobe decision directly so busy is set on the same
    // edge that raises tx_strobe; this prevents a second byte slipping out.
    sni_link u_link (
        .clk     (clk),
        .reset_n (reset_n),
        .tx_go   (tx_go_s),
        .txint   (bus.txint),
        .rxint   (bus.rxint),
        .rx_in   (bus.rdata_m[7:0]),
        .tx_busy (tx_busy_s),
        .rx_hit  (rx_hit_s),
        .rx_byte (rx_byte_s)
    );

    assign unused_rx_hi_s = ^bus.rdata_m[15:8];
    assign tmo_hit_s      = (TIMEOUT != 24'd0) && (tmo_r >= TIMEOUT);

    // Response-gap counter: runs only while waiting on the console, restarts per byte.
    always_comb begin
        tmo_run_s = 1'b0;
        tmo_s     = 24'd0;
        case (state_r)
            ST_W_HDR:  tmo_run_s = (op_r != SNI_WAITNMI);
            ST_W_ECHO: tmo_run_s = 1'b1;
            ST_R_DATA: tmo_run_s = 1'b1;
            default:   tmo_run_s = 1'b0;
        endcase
        if (tmo_run_s && !rx_hit_s) begin
            tmo_s = tmo_r + 24'd1;
        end else begin
            tmo_s = 24'd0;
        end
    end

    // Sequencer next-state and per-cycle output decisions.
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        addr_s     = addr_r;
        len_s      = len_r;
        ping_s     = ping_r;
        cnt_s      = cnt_r;
        err_pend_s = err_pend_r;
        wr_ready_s = 1'b0;
        rd_valid_s = 1'b0;
        done_s     = 1'b0;
        stray_s    = 1'b0;
        tx_go_s    = 1'b0;
        tx_byte_s  = 8'h00;
        case (state_r)
            ST_IDLE: begin
                stray_s = rx_hit_s;
                if (bus.cmd_valid && cmd_ready_r) begin
                    op_s       = bus.cmd_op;
                    addr_s     = bus.cmd_addr;
                    len_s      = bus.cmd_len;
                    ping_s     = bus.cmd_ping;
                    err_pend_s = ERR_OK;
                    state_s    = ST_S_CMD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_S_CMD: begin
                if (!tx_busy_s) begin
                    tx_go_s   = 1'b1;
                    tx_byte_s = {6'd0, op_r};
                    if ((op_r == SNI_READ) || (op_r == SNI_WRITE)) begin
                        state_s = ST_S_A0;
                    end else begin
                        state_s = ST_W_HDR;
                    end
                end else begin
                    state_s = ST_S_CMD;
                end
            end
            ST_S_A0: begin
                if (!tx_busy_s) begin
                    tx_go_s   = 1'b1;
                    tx_byte_s = addr_r[7:0];
                    state_s   = ST_S_A1;
                end else begin
                    state_s = ST_S_A0;
                end
            end
            ST_S_A1: begin
                if (!tx_busy_s) begin
                    tx_go_s   = 1'b1;
                    tx_byte_s = addr_r[15:8];
                    state_s   = ST_S_A2;
                end else begin
                    state_s = ST_S_A1;
                end
            end
            ST_S_A2: begin
                if (!tx_busy_s) begin
                    tx_go_s   = 1'b1;
                    tx_byte_s = addr_r[23:16];
                    state_s   = ST_S_LEN;
                end else begin
                    state_s = ST_S_A2;
                end
            end
            ST_S_LEN: begin
                if (!tx_busy_s) begin
                    tx_go_s   = 1'b1;
                    tx_byte_s = len_r;
                    state_s   = ST_W_HDR;
                end else begin
                    state_s = ST_S_LEN;
                end
            end
            ST_W_HDR: begin
                if (rx_hit_s) begin
                    if (rx_byte_s != hdr_expect(op_r, len_r)) begin
                        err_pend_s = ERR_LEN;
                        state_s    = ST_FIN;
                    end else begin
                        cnt_s = len_r;
                        case (op_r)
                            SNI_PING:  state_s = ST_S_PING;
                            SNI_READ:  state_s = (len_r == 8'd0) ? ST_FIN : ST_R_DATA;
                            SNI_WRITE: state_s = ST_S_DATA;
                            default:   state_s = ST_FIN;
                        endcase
                    end
                end else if (tmo_hit_s) begin
                    err_pend_s = ERR_TIMEOUT;
                    state_s    = ST_FIN;
                end else begin
                    state_s = ST_W_HDR;
                end
            end
            ST_R_DATA: begin
                if (cnt_r == 8'd0) begin
                    state_s = ST_FIN;
                end else if (rx_hit_s) begin
                    rd_valid_s = 1'b1;
                    cnt_s      = cnt_r - 8'd1;
                    state_s    = (cnt_r == 8'd1) ? ST_FIN : ST_R_DATA;
                end else if (tmo_hit_s) begin
                    err_pend_s = ERR_TIMEOUT;
                    state_s    = ST_FIN;
                end else begin
                    state_s = ST_R_DATA;
                end
            end
            ST_S_DATA: begin
                if (cnt_r == 8'd0) begin
                    // Finish only once the last payload byte has left the UART.
                    state_s = tx_busy_s ? ST_S_DATA : ST_FIN;
                end else if (!tx_busy_s && bus.wr_valid) begin
                    wr_ready_s = 1'b1;
                    tx_go_s    = 1'b1;
                    tx_byte_s  = bus.wr_data;
                    cnt_s      = cnt_r - 8'd1;
                    state_s    = ST_S_DATA;
                end else begin
                    state_s = ST_S_DATA;
                end
            end
            ST_S_PING: begin
                if (!tx_busy_s) begin
                    tx_go_s   = 1'b1;
                    tx_byte_s = ping_r;
                    state_s   = ST_W_ECHO;
                end else begin
                    state_s = ST_S_PING;
                end
            end
            ST_W_ECHO: begin
                if (rx_hit_s) begin
                    err_pend_s = (rx_byte_s == ping_r) ? ERR_OK : ERR_ECHO;
                    state_s    = ST_FIN;
                end else if (tmo_hit_s) begin
                    err_pend_s = ERR_TIMEOUT;
                    state_s    = ST_FIN;
                end else begin
                    state_s = ST_W_ECHO;
                end
            end
            ST_FIN: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, latched command fields and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            op_r       <= 2'd0;
            addr_r     <= 24'd0;
            len_r      <= 8'd0;
            ping_r     <= 8'd0;
            cnt_r      <= 8'd0;
            tmo_r      <= 24'd0;
            err_pend_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            op_r       <= op_s;
            addr_r     <= addr_s;
            len_r      <= len_s;
            ping_r     <= ping_s;
            cnt_r      <= cnt_s;
            tmo_r      <= tmo_s;
            err_pend_r <= err_pend_s;
        end
    end

    // Registered outputs; err_code only changes alongside done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_r <= 1'b0;
            wr_ready_r  <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= 8'h00;
            done_r      <= 1'b0;
            err_code_r  <= 2'd0;
            stray_r     <= 1'b0;
            tx_strobe_r <= 1'b0;
            tx_data_r   <= 16'h0100;
        end else begin
            cmd_ready_r <= (state_s == ST_IDLE);
            wr_ready_r  <= wr_ready_s;
            rd_valid_r  <= rd_valid_s;
            done_r      <= done_s;
            stray_r     <= stray_s;
            tx_strobe_r <= tx_go_s;
            rd_data_r   <= rd_valid_s ? rx_byte_s : rd_data_r;
            err_code_r  <= done_s ? err_pend_r : err_code_r;
            tx_data_r   <= tx_go_s ? {TX_HI, tx_byte_s} : tx_data_r;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.wr_ready  = wr_ready_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.done      = done_r;
    assign bus.err_code  = err_code_r;
    assign bus.stray     = stray_r;
    assign bus.tx_strobe = tx_strobe_r;
    assign bus.tx_data   = tx_data_r;

endmodule

// File: tb/tb_sni_host.sv
// Bench for sni_host: a UART/console model answers each command; expected
// frames, read bytes and completion codes come from the protocol rules.
module tb_sni_host;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    sni_host_if bus ();

    sni_host #(.TIMEOUT(24'd100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    logic [15:0] tx_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  src_q[$];
    int done_cnt = 0;
    int stray_cnt = 0;
    int wrr_cnt = 0;
    logic [1:0] last_err = 2'd0;
    int unsigned last_done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.tx_strobe) tx_q.push_back(bus.tx_data);
        if (bus.rd_valid) rd_q.push_back(bus.rd_data);
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            last_err <= bus.err_code;
            last_done_cyc <= cyc;
        end
        if (bus.stray) stray_cnt <= stray_cnt + 1;
        if (bus.wr_ready) wrr_cnt <= wrr_cnt + 1;
    end

    // UART transmitter model: busy for a random few cycles after each strobe.
    initial begin
        bus.txint = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_strobe) begin
                bus.txint = 1'b1;
                repeat ($urandom_range(2, 6)) @(negedge clk);
                bus.txint = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference rule for the console's first reply.
    function automatic logic [7:0] model_hdr(input logic [1:0] op, input logic [7:0] len);
        if (op == 2'd0) return 8'h01;
        if (op == 2'd1) return len;
        return 8'h00;
    endfunction

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (tx_q.size() < n && k < 3000) begin tick(1); k++; end
        while (bus.txint && k < 3000) begin tick(1); k++; end
        chk({tag, "_tx_wait"}, 32'(tx_q.size() >= n), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        bus.rdata_m = {8'($urandom), b};
        bus.rxint = 1'b1;
        @(negedge clk);
        bus.rxint = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len,
                         input logic [7:0] ping, input string tag);
        int k = 0;
        while (!bus.cmd_ready && k < 200) begin tick(1); k++; end
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_addr = addr;
        bus.cmd_len = len;
        bus.cmd_ping = ping;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'($urandom);
        bus.cmd_addr = 24'($urandom);
        bus.cmd_len = 8'($urandom);
        bus.cmd_ping = 8'($urandom);
    endtask

    task automatic drive_wr(input logic [7:0] b, input string tag);
        int k = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data = b;
        do begin @(negedge clk); k++; end while (!bus.wr_ready && k < 500);
        chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
        bus.wr_valid = 1'b0;
        bus.wr_data = 8'($urandom);
    endtask

    task automatic wait_done(input int d0, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < 20000) begin tick(1); k++; end
        chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    // One full command against the console model, then compare everything observed.
    task automatic run_txn(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len,
                           input logic [7:0] ping, input bit hdr_ok, input logic [7:0] bad_hdr,
                           input bit echo_ok, input int gap, input string tag);
        logic [7:0] exp_tx[$];
        logic [7:0] exp_rd[$];
        logic [1:0] exp_err;
        int d0, w0, nh, exp_w;
        tx_q.delete();
        rd_q.delete();
        d0 = done_cnt;
        w0 = wrr_cnt;
        exp_w = 0;
        exp_tx.push_back({6'd0, op});
        if (op == 2'd1 || op == 2'd2) begin
            exp_tx.push_back(addr[7:0]);
            exp_tx.push_back(addr[15:8]);
            exp_tx.push_back(addr[23:16]);
            exp_tx.push_back(len);
        end
        nh = exp_tx.size();
        issue(op, addr, len, ping, tag);
        wait_tx(nh, tag);
        if (op == 2'd3) tick(gap);
        send_rx(hdr_ok ? model_hdr(op, len) : bad_hdr);
        exp_err = 2'd0;
        if (!hdr_ok) begin
            exp_err = 2'd1;
        end else if (op == 2'd0) begin
            exp_tx.push_back(ping);
            wait_tx(2, tag);
            send_rx(echo_ok ? ping : (ping ^ 8'hFF));
            exp_err = echo_ok ? 2'd0 : 2'd2;
        end else if (op == 2'd1) begin
            for (int i = 0; i < int'(len); i++) begin
                tick($urandom_range(0, 5));
                send_rx(src_q[i]);
                exp_rd.push_back(src_q[i]);
            end
        end else if (op == 2'd2) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_tx.push_back(src_q[i]);
                tick(gap);
                drive_wr(src_q[i], tag);
            end
            exp_w = int'(len);
        end
        wait_done(d0, tag);
        tick(3);
        chk({tag, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
        chk({tag, "_err_at_done"}, 32'(last_err), 32'(exp_err));
        chk({tag, "_err_held"}, 32'(bus.err_code), 32'(exp_err));
        chk({tag, "_tx_count"}, 32'(tx_q.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            chk({tag, "_tx_byte"}, {16'd0, tx_q[i]}, {16'd0, 8'h01, exp_tx[i]});
        chk({tag, "_rd_count"}, 32'(rd_q.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
            chk({tag, "_rd_byte"}, {24'd0, rd_q[i]}, {24'd0, exp_rd[i]});
        chk({tag, "_wr_pulses"}, 32'(wrr_cnt - w0), 32'(exp_w));
    endtask

    initial begin
        int d0, s0;
        int unsigned t0;
        logic [1:0] rop;
        logic [7:0] rlen;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'd0;
        bus.cmd_addr = 24'd0;
        bus.cmd_len = 8'd0;
        bus.cmd_ping = 8'd0;
        bus.wr_valid = 1'b0;
        bus.wr_data = 8'd0;
        bus.rxint = 1'b0;
        bus.rdata_m = 16'd0;

        // Reset values.
        tick(3);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0100);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err_code), 32'd0);
        chk("rst_pulses", {28'd0, bus.tx_strobe, bus.rd_valid, bus.wr_ready, bus.stray}, 32'd0);
        reset_n = 1'b1;
        tick(2);
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // PING good echo, then echo mismatch.
        run_txn(2'd0, 24'd0, 8'd0, 8'hA5, 1'b1, 8'h00, 1'b1, 0, "ping_ok");
        run_txn(2'd0, 24'd0, 8'd0, 8'hA5, 1'b1, 8'h00, 1'b0, 0, "ping_echo");

        // READ of three bytes.
        src_q = '{8'h11, 8'h22, 8'h33};
        run_txn(2'd1, 24'hF50010, 8'd3, 8'h00, 1'b1, 8'h00, 1'b0, 0, "read3");

        // WRITE two bytes with a 10-cycle data gap.
        src_q = '{8'h77, 8'h88};
        run_txn(2'd2, 24'hE00000, 8'd2, 8'h00, 1'b1, 8'h00, 1'b0, 10, "write2");

        // READ with zero length finishes right after the header.
        run_txn(2'd1, 24'h123456, 8'd0, 8'h00, 1'b1, 8'h00, 1'b0, 0, "read0");

        // Header mismatch, then a byte while idle.
        run_txn(2'd1, 24'h000100, 8'd4, 8'h00, 1'b0, 8'h02, 1'b0, 0, "bad_len");
        s0 = stray_cnt;
        d0 = done_cnt;
        send_rx(8'h3C);
        tick(3);
        chk("stray_pulse", 32'(stray_cnt), 32'(s0 + 1));
        chk("stray_no_done", 32'(done_cnt), 32'(d0));

        // Timeout while reading.
        tx_q.delete();
        rd_q.delete();
        d0 = done_cnt;
        issue(2'd1, 24'h7E0000, 8'd2, 8'h00, "tmo");
        wait_tx(5, "tmo");
        send_rx(8'h02);
        tick(2);
        send_rx(8'hAA);
        t0 = cyc;
        wait_done(d0, "tmo");
        tick(2);
        chk("tmo_err", 32'(last_err), 32'd3);
        chk("tmo_rd_count", 32'(rd_q.size()), 32'd1);
        if (rd_q.size() > 0) chk("tmo_rd_byte", 32'(rd_q[0]), 32'hAA);
        chk("tmo_latency_window", 32'((last_done_cyc - t0 >= 95) && (last_done_cyc - t0 <= 115)), 32'd1);

        // WAITNMI waits far past TIMEOUT without expiring.
        run_txn(2'd3, 24'd0, 8'd0, 8'h00, 1'b1, 8'h00, 1'b0, 10000, "waitnmi");

        // Randomised commands.
        for (int it = 0; it < 10; it++) begin
            rop = 2'($urandom_range(0, 3));
            rlen = 8'($urandom_range(0, 5));
            src_q.delete();
            for (int i = 0; i < 6; i++) src_q.push_back(8'($urandom));
            run_txn(rop, 24'($urandom), rlen, 8'($urandom), ($urandom_range(0, 4) != 0),
                    model_hdr(rop, rlen) ^ 8'($urandom_range(1, 255)), $urandom_range(0, 1) != 0,
                    (rop == 2'd3) ? $urandom_range(0, 300) : $urandom_range(0, 12), "rand");
        end

        // Reset in the middle of a READ abandons it without done.
        d0 = done_cnt;
        tx_q.delete();
        issue(2'd1, 24'h00C000, 8'd3, 8'h00, "rst_mid");
        wait_tx(5, "rst_mid");
        send_rx(8'h03);
        send_rx(8'h11);
        reset_n = 1'b0;
        tick(3);
        chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_mid_tx_data", 32'(bus.tx_data), 32'h0100);
        chk("rst_mid_err", 32'(bus.err_code), 32'd0);
        reset_n = 1'b1;
        tick(300);
        chk("rst_mid_no_done", 32'(done_cnt), 32'(d0));
        chk("rst_mid_idle", 32'(bus.cmd_ready), 32'd1);
        run_txn(2'd0, 24'd0, 8'd0, 8'h3E, 1'b1, 8'h00, 1'b1, 0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
